// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder/loader.
//   kind_e     : descriptor kind carried on in_kind (6 and 7 are illegal)
//   state_e    : loader FSM states
//   OP_*       : RV32I major opcodes for the supported subset
//   F3_*       : fixed funct3 values for kinds that do not take funct3 from the descriptor
//   TERM_INSTR : terminator word (jal x0,0) appended on finish
//   imm_fits   : true when a 21-bit immediate is a sign-extended value of the given width
package instr_enc_pkg;

  typedef enum logic [2:0] {
    K_LW  = 3'd0,
    K_SW  = 3'd1,
    K_R   = 3'd2,
    K_BEQ = 3'd3,
    K_I   = 3'd4,
    K_JAL = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    S_LOAD,
    S_TERM,
    S_DONE
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [31:0] TERM_INSTR = 32'h0000_006F;

  // All bits from the sign position upward must agree for the value to fit.
  function automatic logic imm_fits(input logic [20:0] imm, input int unsigned bits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = bits; i < 21; i++) begin
      if (imm[i] != imm[bits-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: turns one instruction descriptor into a 32-bit
// RV32I word and flags descriptors that must not be written.
//   in_kind/in_rd/in_rs1/in_rs2/in_funct3/in_funct7b5/in_imm : descriptor fields
//   word    : encoded instruction
//   illegal : unknown kind, misaligned BEQ/JAL offset, or (with
//             ENC_IMM_RANGE_CHECK_EN defined) an immediate out of range for its kind
// Build option: `define ENC_IMM_RANGE_CHECK_EN to reject out-of-range immediates
// instead of truncating them.
module instr_field_pack (
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [20:0] in_imm,
  output logic [31:0] word,
  output logic        illegal
);
  import instr_enc_pkg::*;

  logic range_bad;

`ifdef ENC_IMM_RANGE_CHECK_EN
  always_comb begin
    range_bad = 1'b0;
    case (in_kind)
      K_LW, K_SW, K_I: range_bad = !imm_fits(in_imm, 12);
      K_BEQ:           range_bad = !imm_fits(in_imm, 13);
      default:         range_bad = 1'b0;  // JAL spans the full 21-bit field
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (in_kind)
      K_LW:  word = {in_imm[11:0], in_rs1, F3_LW, in_rd, OP_LW};
      K_SW:  word = {in_imm[11:5], in_rs2, in_rs1, F3_SW, in_imm[4:0], OP_SW};
      K_R:   word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      K_BEQ: begin
        word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BEQ,
                   in_imm[4:1], in_imm[11], OP_BEQ};
        illegal = in_imm[0];
      end
      K_I:   word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
      K_JAL: begin
        word    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        illegal = in_imm[0];
      end
      default: illegal = 1'b1;
    endcase
    if (range_bad) illegal = 1'b1;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test-path loader: accepts instruction descriptors over valid/ready,
// encodes them to RV32I words and writes them sequentially into imem. A finish
// pulse appends the terminator (jal x0,0); clear rewinds for a fresh load.
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready       : descriptor handshake
//   in_kind..in_imm         : descriptor fields
//   finish, clear           : single-cycle control pulses
//   imem_we/addr/wdata      : registered imem write port (one-cycle latency)
//   count, full, done, err  : load status
// Build option: `define ENC_IMM_RANGE_CHECK_EN enables immediate range rejects.
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [20:0]       in_imm,
  input  logic              finish,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);
  import instr_enc_pkg::*;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;

  instr_field_pack u_pack (
    .in_kind     (in_kind),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_imm      (in_imm),
    .word        (enc_word),
    .illegal     (enc_illegal)
  );

  assign full     = (count == DEPTH);
  assign in_ready = (state == S_LOAD) && !full;
  assign accept   = in_valid && in_ready;

  // Pointer and count advance on the accept edge, so the write cycle already
  // shows the updated count; this keeps full exact under back-to-back accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      ptr        <= BASE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (clear) begin
      state     <= S_LOAD;
      ptr       <= BASE;
      imem_we   <= 1'b0;
      imem_addr <= BASE;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (enc_illegal) begin
              err <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc_word;
              ptr        <= ptr + 1'b1;
              count      <= count + 1'b1;
            end
          end
          if (finish) state <= S_TERM;
        end
        S_TERM: begin
          // full here already reflects an accept taken alongside finish.
          if (!full) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= TERM_INSTR;
            ptr        <= ptr + 1'b1;
            count      <= count + 1'b1;
          end else begin
            err <= 1'b1;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: ;
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int AW    = 2;
  localparam int BASE  = 2;
  localparam int DEPTH = 4;
  localparam logic [31:0] USE_MODEL = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, finish, clear;
  logic [2:0]    in_kind, in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic          in_funct7b5;
  logic [20:0]   in_imm;
  logic          imem_we, full, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
    .finish(finish), .clear(clear), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t  expq[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   mptr, mcount;
  logic merr, mdone;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoder built from shifts and masks.
  function automatic logic [31:0] ref_enc(input logic [2:0] k, input logic [4:0] rd, rs1, rs2,
                                          input logic [2:0] f3, input logic f7,
                                          input logic [20:0] imm, output logic bad);
    logic [31:0] m, d, s1, s2, w;
    int v;
    m  = {11'b0, imm};
    d  = {27'b0, rd};
    s1 = {27'b0, rs1};
    s2 = {27'b0, rs2};
    v  = $signed({{11{imm[20]}}, imm});
    w  = '0;
    bad = 1'b0;
    case (k)
      3'd0: w = ((m & 32'hfff) << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
      3'd1: w = (((m >> 5) & 32'h7f) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                | ((m & 32'h1f) << 7) | 32'h23;
      3'd2: w = ({31'b0, f7} << 30) | (s2 << 20) | (s1 << 15) | ({29'b0, f3} << 12)
                | (d << 7) | 32'h33;
      3'd3: begin
        w = (((m >> 12) & 1) << 31) | (((m >> 5) & 32'h3f) << 25) | (s2 << 20) | (s1 << 15)
            | (((m >> 1) & 32'hf) << 8) | (((m >> 11) & 1) << 7) | 32'h63;
        bad = imm[0];
      end
      3'd4: w = ((m & 32'hfff) << 20) | (s1 << 15) | ({29'b0, f3} << 12) | (d << 7) | 32'h13;
      3'd5: begin
        w = (((m >> 20) & 1) << 31) | (((m >> 1) & 32'h3ff) << 21) | (((m >> 11) & 1) << 20)
            | (m & 32'h000ff000) | (d << 7) | 32'h6f;
        bad = imm[0];
      end
      default: bad = 1'b1;
    endcase
`ifdef ENC_IMM_RANGE_CHECK_EN
    if ((k == 3'd0 || k == 3'd1 || k == 3'd4) && (v < -2048 || v > 2047)) bad = 1'b1;
    if (k == 3'd3 && (v < -4096 || v > 4095)) bad = 1'b1;
`endif
    return w;
  endfunction

  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = expq.pop_front();
        check("wr_addr", {30'b0, imem_addr}, {30'b0, e.addr});
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic model_reset();
    mptr = BASE; mcount = 0; merr = 1'b0; mdone = 1'b0;
  endtask

  task automatic term_model();
    wr_t e;
    if (mcount < DEPTH) begin
      e.addr = mptr[AW-1:0];
      e.data = 32'h0000_006F;
      expq.push_back(e);
      mptr = (mptr + 1) % DEPTH;
      mcount++;
    end else begin
      merr = 1'b1;
    end
    mdone = 1'b1;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic f7, input logic [20:0] imm, input logic fin,
                      input logic [31:0] lit);
    int   w;
    logic bad;
    wr_t  e;
    in_valid = 1'b1; in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7b5 = f7; in_imm = imm;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) begin
      check("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    finish = fin;
    e.data = ref_enc(k, rd, rs1, rs2, f3, f7, imm, bad);
    if (lit != USE_MODEL) e.data = lit;
    if (bad) begin
      merr = 1'b1;
    end else begin
      e.addr = mptr[AW-1:0];
      expq.push_back(e);
      mptr = (mptr + 1) % DEPTH;
      mcount++;
    end
    if (fin) term_model();
    @(posedge clk); #1;
    in_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    term_model();
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    expq.delete();
    model_reset();
  endtask

  task automatic hold_valid(input int n, input logic fin);
    in_valid = 1'b1; in_kind = 3'd4; finish = fin;
    repeat (n) begin @(posedge clk); #1; end
    in_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic status(input string tag);
    check({tag, ":count"}, {29'b0, count}, mcount);
    check({tag, ":err"},   {31'b0, err},   {31'b0, merr});
    check({tag, ":done"},  {31'b0, done},  {31'b0, mdone});
    check({tag, ":full"},  {31'b0, full},  {31'b0, mcount == DEPTH});
    check({tag, ":ready"}, {31'b0, in_ready}, {31'b0, !mdone && mcount < DEPTH});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; finish = 1'b0; clear = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
    in_funct7b5 = 1'b0; in_imm = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    {31'b0, imem_we}, 32'd0);
    check("rst_addr",  {30'b0, imem_addr}, BASE);
    check("rst_wdata", imem_wdata, 32'd0);
    reset = 1'b0;
    status("rst");

    // addi x1,x0,5 ; lw x2,8(x1)
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b0, 32'h0050_0093);
    send(3'd0, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 21'd8, 1'b0, 32'h0080_A103);
    status("two");
    do_clear();
    status("clr1");

    // sw/add/sub back-to-back, then beq -4 fills the memory (addresses wrap 2,3,0,1)
    send(3'd1, 5'd0, 5'd0, 5'd2, 3'd0, 1'b0, 21'd4, 1'b0, 32'h0020_2223);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b0, 32'h0020_81B3);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0, 1'b0, 32'h4020_81B3);
    status("b2b");
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -21'sd4, 1'b0, 32'hFE20_8EE3);
    status("full");
    hold_valid(3, 1'b0);
    status("held");
    do_finish();
    repeat (2) begin @(posedge clk); #1; end
    status("fin_full");
    do_clear();
    status("clr2");

    // rejects: misaligned beq, illegal kinds
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd3, 1'b0, USE_MODEL);
    status("beq_odd");
    send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 21'd0, 1'b0, USE_MODEL);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd9, 1'b0, USE_MODEL);
    status("rejects");
    do_clear();

    // accept together with finish, then everything ignored in DONE
    send(3'd4, 5'd5, 5'd6, 5'd0, 3'd7, 1'b0, 21'h1FFFFF, 1'b1, USE_MODEL);
    repeat (2) begin @(posedge clk); #1; end
    status("acc_fin");
    hold_valid(3, 1'b1);
    status("done_hold");
    do_clear();

    // clear while the terminator is pending cancels it
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b0, USE_MODEL);
    do_finish();
    do_clear();
    check("clr_term_we", {31'b0, imem_we}, 32'd0);
    status("clr_term");
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b0, 32'h0050_0093);
    send(3'd0, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 21'd2048, 1'b0, USE_MODEL);
    status("lw2048");
    do_clear();

    // randomized loads, each closed by finish
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (mcount < DEPTH)
          send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 1'($urandom),
               ($urandom_range(0, 1) != 0) ? 21'($urandom) : 21'($urandom_range(0, 64)),
               1'b0, USE_MODEL);
      end
      do_finish();
      repeat (2) begin @(posedge clk); #1; end
      status("rand");
      do_clear();
    end

    // reset mid-load
    send(3'd2, 5'd7, 5'd8, 5'd9, 3'd5, 1'b1, 21'd0, 1'b0, USE_MODEL);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expq.delete();
    model_reset();
    check("mid_rst_wdata", imem_wdata, 32'd0);
    status("mid_rst");

    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
